// File: rtl/ysyx_22041412_ex_mem_buf.sv
// EX->MEM pipeline buffer: two-entry skid FIFO between execute and memory stages,
// with a registered ready toward EX and a forwarding view of the oldest entry.
module ysyx_22041412_ex_mem_buf #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid_i,
    input  logic              alu_stall_i,
    output logic              ex_ready_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [RD_W-1:0]   rd_i,
    input  logic              rd_wen_i,
    input  logic              mem_ren_i,
    input  logic              mem_wen_i,
    input  logic [2:0]        mem_func3_i,
    input  logic              flush_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [DATA_W-1:0] mem_result_o,
    output logic [DATA_W-1:0] mem_store_data_o,
    output logic [DATA_W-1:0] mem_pc_o,
    output logic [RD_W-1:0]   mem_rd_o,
    output logic              mem_rd_wen_o,
    output logic              mem_ren_o,
    output logic              mem_wen_o,
    output logic [2:0]        mem_func3_o,
    output logic              fwd_valid_o,
    output logic [RD_W-1:0]   fwd_rd_o,
    output logic [DATA_W-1:0] fwd_data_o,
    output logic              fwd_is_load_o
);

    localparam int PW = 3*DATA_W + RD_W + 6;

    logic [PW-1:0] in_pld;
    logic [PW-1:0] main_pld;
    logic [PW-1:0] skid_pld;
    logic          main_v;
    logic          skid_v;
    logic          ready_q;
    logic          accept;
    logic          pop;
    logic          main_v_n;
    logic          skid_v_n;
    logic          load_main;
    logic          load_skid;
    logic          main_from_skid;

    assign in_pld = {alu_result_i, store_data_i, pc_i, rd_i,
                     rd_wen_i, mem_ren_i, mem_wen_i, mem_func3_i};

    assign accept = ex_valid_i & ~alu_stall_i & ready_q & ~flush_i;
    assign pop    = main_v & mem_ready_i;

    always_comb begin
        main_v_n       = main_v;
        skid_v_n       = skid_v;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush_i) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else if (!main_v) begin
            if (accept) begin
                main_v_n  = 1'b1;
                load_main = 1'b1;
            end
        end else if (!skid_v) begin
            if (accept && pop) begin
                load_main = 1'b1;
            end else if (accept) begin
                skid_v_n  = 1'b1;
                load_skid = 1'b1;
            end else if (pop) begin
                main_v_n = 1'b0;
            end
        end else if (pop) begin
            // Skid is younger: it only ever advances into main, never bypasses it.
            skid_v_n       = 1'b0;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            ready_q  <= 1'b1;
            main_pld <= '0;
            skid_pld <= '0;
        end else begin
            main_v  <= main_v_n;
            skid_v  <= skid_v_n;
            ready_q <= ~skid_v_n;
            if (load_main) begin
                main_pld <= main_from_skid ? skid_pld : in_pld;
            end
            if (load_skid) begin
                skid_pld <= in_pld;
            end
        end
    end

    assign ex_ready_o  = ready_q;
    assign mem_valid_o = main_v;
    assign {mem_result_o, mem_store_data_o, mem_pc_o, mem_rd_o,
            mem_rd_wen_o, mem_ren_o, mem_wen_o, mem_func3_o} = main_pld;

    // Only the head is forwardable; the skid entry is left to the bypass stall check.
    assign fwd_valid_o   = main_v & mem_rd_wen_o & (|mem_rd_o);
    assign fwd_rd_o      = mem_rd_o;
    assign fwd_data_o    = mem_result_o;
    assign fwd_is_load_o = main_v & mem_ren_o;

endmodule

// File: doc/ysyx_22041412_ex_mem_buf.md
# ysyx_22041412_ex_mem_buf

EX→MEM pipeline buffer. Captures each completed execute-stage result (ALU/MUL result, store data, destination register and memory-control bits) once the ALU has dropped `stall`. Presents the results in order to the memory stage through a valid/ready handshake, using a two-entry skid buffer so that `ex_ready_o` is a registered signal. Also exports the oldest held entry as a forwarding source for the decode/bypass logic.

## Interface
Parameters:
- `DATA_W`, 64, width of result, store data and PC
- `RD_W`, 5, register-index width

Ports:
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `ex_valid_i` in 1: EX holds a valid instruction
- `alu_stall_i` in 1: ALU `stall` output; the result is not final while this is high
- `ex_ready_o` out 1: buffer can accept; registered
- `alu_result_i` in DATA_W: ALU `result` (address for load/store)
- `store_data_i` in DATA_W: rs2 value for stores
- `pc_i` in DATA_W: instruction PC
- `rd_i` in RD_W: destination register
- `rd_wen_i` in 1: instruction writes rd
- `mem_ren_i` / `mem_wen_i` in 1: load / store
- `mem_func3_i` in 3: load/store size/sign (func3)
- `flush_i` in 1: discard all held and incoming entries
- `mem_valid_o` out 1: head entry valid
- `mem_ready_i` in 1: MEM consumes head
- `mem_result_o`, `mem_store_data_o`, `mem_pc_o` out DATA_W: head fields
- `mem_rd_o` out RD_W; `mem_rd_wen_o`, `mem_ren_o`, `mem_wen_o` out 1; `mem_func3_o` out 3: head fields
- `fwd_valid_o` out 1: head valid & rd_wen & rd≠0
- `fwd_rd_o` out RD_W; `fwd_data_o` out DATA_W: head rd / result
- `fwd_is_load_o` out 1: head is a load; `fwd_data_o` is not usable and decode must stall

## Operation
- Storage: head entry (main) and skid entry, each with a valid bit and all payload fields.
- accept = `ex_valid_i & ~alu_stall_i & ex_ready_o & ~flush_i`.
- pop = `mem_valid_o & mem_ready_i`.
- State = {main_v, skid_v}:
  - EMPTY {0,0}: accept → ONE, with the entry written to main.
  - ONE {1,0}:
    - accept & pop → ONE, main replaced.
    - accept & ~pop → TWO, entry written to skid.
    - pop & ~accept → EMPTY.
    - otherwise hold.
  - TWO {1,1}: `ex_ready_o`=0, so there is no accept. pop → ONE with skid moved to main. Otherwise hold.
- `ex_ready_o` is registered and equals ~next skid_v. It is high in EMPTY and ONE, low in TWO.
- Order is strictly FIFO. The skid entry never overtakes main.
- `flush_i` has priority over all other events. Next state is EMPTY, and a concurrent accept is dropped. A concurrent pop still completes toward MEM in the same cycle; the valid bits are cleared at the edge.
- Payload registers load only when written; they need not be cleared on pop or flush.
- `mem_*` outputs are driven directly from the main registers, with no combinational path from `ex_*` inputs. Fields are don't-care when `mem_valid_o`=0.
- `fwd_*` outputs are derived combinationally from main only. The skid entry is younger, so the bypass logic treats it as not yet forwardable. In TWO, decode must stall if it depends on the skid rd. That check is the bypass logic's job, and the skid rd is not exported.
- Widths: all payload is stored verbatim, with no extension or truncation.

## Timing
- Reset (asynchronous, rst_n=0):
  - main_v=skid_v=0, so `mem_valid_o`=0 and `fwd_valid_o`=0.
  - `ex_ready_o`=1.
  - All payload registers are 0, so every `mem_*` and `fwd_*` data output is 0.
- Latency: accept at edge N gives `mem_valid_o`=1 after edge N, when the buffer was EMPTY.
- Throughput: with `mem_ready_i` held at 1, sustains one entry per cycle.
- `ex_ready_o` falls in the cycle after the skid fills and rises in the cycle after the pop that empties the skid.
- `alu_stall_i`=1 blocks accept. The EX stage holds its inputs stable until stall drops; the buffer does not sample them.
- Reset asserted mid-operation clears both entries immediately, including any in-flight handshake.

## Test plan
- Reset: rst_n=0 with arbitrary inputs → `mem_valid_o`=0, `ex_ready_o`=1, `mem_result_o`=0, `fwd_valid_o`=0. Release → buffer is in EMPTY.
- Single pass-through: accept result=0x80000010, rd=5, rd_wen=1, `mem_ready_i`=1 → next cycle `mem_valid_o`=1, `mem_result_o`=0x80000010, `fwd_valid_o`=1, `fwd_rd_o`=5. Popped the cycle after, the buffer returns to EMPTY.
- Backpressure: hold `mem_ready_i`=0 and offer A=1 then B=2 on consecutive cycles → `ex_ready_o`=0 after B, and a C offered then is not accepted. Release ready → outputs A, B, C in order, and `ex_ready_o` returns to 1 one cycle after B moves to main.
- ALU stall: `ex_valid_i`=1 with `alu_stall_i`=1 for 3 cycles, result changing each cycle → nothing is accepted. On the cycle stall=0 with result=0x2A, exactly one entry of 0x2A is captured.
- Flush: in TWO, assert `flush_i` together with `ex_valid_i` → next cycle `mem_valid_o`=0 and `ex_ready_o`=1, and the flushed and incoming entries never appear.
- Forward qualifiers:
  - rd=0 with rd_wen=1 → `fwd_valid_o`=0.
  - A load with rd=7 → `fwd_valid_o`=1 and `fwd_is_load_o`=1.
